// File: rtl/inst_queue.sv
// Fetch-to-decode instruction prefetch queue of DEPTH {inst, pc} entries; INST_QUEUE_BYPASS_EN adds empty-queue pass-through.
// Latency: 1 cycle push-to-head (0 cycles via bypass); one push and one pop per cycle sustained.
// Backpressure: o_inst_ack drops when full, flushing or in reset; a pop never frees a slot for the same cycle.
module inst_queue #(
  parameter int INST_WIDTH = 32,
  parameter int ADDR_WIDTH = 12,
  parameter int DEPTH      = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_flush,
  output logic                     o_flush,
  input  logic [INST_WIDTH-1:0]    i_inst,
  input  logic [ADDR_WIDTH-1:0]    i_inst_pc,
  input  logic                     i_inst_ready,
  output logic                     o_inst_ack,
  output logic [INST_WIDTH-1:0]    o_inst,
  output logic [ADDR_WIDTH-1:0]    o_inst_pc,
  output logic                     o_inst_ready,
  input  logic                     i_inst_ack,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [INST_WIDTH-1:0] inst_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] pc_mem   [DEPTH];
  logic [PW-1:0]         rd_ptr, wr_ptr;
  logic [CW-1:0]         count;

  logic full, empty, bypass, pop, do_pop, push;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

`ifdef INST_QUEUE_BYPASS_EN
  assign bypass = empty && i_inst_ready;
`else
  assign bypass = 1'b0;
`endif

  assign o_flush      = i_flush;
  assign o_inst_ack   = !full && !i_flush && !i_rst;
  assign o_inst_ready = (!empty || bypass) && !i_flush && !i_rst;
  assign o_inst       = bypass ? i_inst    : inst_mem[rd_ptr];
  assign o_inst_pc    = bypass ? i_inst_pc : pc_mem[rd_ptr];
  assign o_count      = count;

  assign pop    = o_inst_ready && i_inst_ack;
  assign do_pop = pop && !empty;
  // A word consumed straight through the bypass is never written.
  assign push   = i_inst_ready && o_inst_ack && !(bypass && pop);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        inst_mem[i] <= '0;
        pc_mem[i]   <= '0;
      end
    end else if (i_flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        inst_mem[wr_ptr] <= i_inst;
        pc_mem[wr_ptr]   <= i_inst_pc;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (push && !do_pop)
        count <= count + 1'b1;
      else if (!push && do_pop)
        count <= count - 1'b1;
    end
  end

endmodule

// File: tb/tb_inst_queue.sv
// Bench for inst_queue: queue-based reference model checked every cycle plus directed literal checks.
module tb_inst_queue;

  localparam int IW = 32;
  localparam int AW = 12;
  localparam int D  = 4;

  logic          i_clk = 1'b0;
  logic          i_rst, i_flush, i_inst_ready, i_inst_ack;
  logic [IW-1:0] i_inst;
  logic [AW-1:0] i_inst_pc;
  logic          o_flush, o_inst_ack, o_inst_ready;
  logic [IW-1:0] o_inst;
  logic [AW-1:0] o_inst_pc;
  logic [2:0]    o_count;

  inst_queue #(.INST_WIDTH(IW), .ADDR_WIDTH(AW), .DEPTH(D)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_flush(i_flush), .o_flush(o_flush),
    .i_inst(i_inst), .i_inst_pc(i_inst_pc), .i_inst_ready(i_inst_ready),
    .o_inst_ack(o_inst_ack), .o_inst(o_inst), .o_inst_pc(o_inst_pc),
    .o_inst_ready(o_inst_ready), .i_inst_ack(i_inst_ack), .o_count(o_count)
  );

  always #5 i_clk = ~i_clk;

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: a plain queue of {pc, inst} words.
  logic [AW+IW-1:0] mq[$];
  bit               model_valid = 0;

  always @(negedge i_clk) begin
    bit exp_ack, exp_rdy, through;
    logic [AW+IW-1:0] head;
    exp_ack = (mq.size() < D) && !i_flush && !i_rst;
    through = 0;
`ifdef INST_QUEUE_BYPASS_EN
    through = (mq.size() == 0) && i_inst_ready;
`endif
    exp_rdy = ((mq.size() > 0) || through) && !i_flush && !i_rst;
    head = (mq.size() > 0) ? mq[0] : {i_inst_pc, i_inst};
    if (model_valid) begin
      check("m_flush", 64'(o_flush), 64'(i_flush));
      check("m_ack",   64'(o_inst_ack), 64'(exp_ack));
      check("m_ready", 64'(o_inst_ready), 64'(exp_rdy));
      check("m_count", 64'(o_count), 64'(mq.size()));
      if (exp_rdy) begin
        check("m_inst", 64'(o_inst), 64'(head[IW-1:0]));
        check("m_pc",   64'(o_inst_pc), 64'(head[AW+IW-1:IW]));
      end
    end
    // Effect of the coming rising edge.
    if (i_rst) begin
      mq.delete();
      model_valid = 1;
    end else if (i_flush) begin
      mq.delete();
    end else if (!(through && exp_rdy && i_inst_ack)) begin
      bit do_push;
      do_push = i_inst_ready && exp_ack;
      if (exp_rdy && i_inst_ack && mq.size() > 0) void'(mq.pop_front());
      if (do_push) mq.push_back({i_inst_pc, i_inst});
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  logic [IW-1:0] fill_w [4];

  initial begin
    fill_w[0] = 32'hF142; fill_w[1] = 32'hF088; fill_w[2] = 32'hD142; fill_w[3] = 32'hB140;
    i_rst = 1; i_flush = 0; i_inst_ready = 0; i_inst_ack = 0; i_inst = '0; i_inst_pc = '0;

    // Reset for two cycles.
    tick();
    check("rst_ack_low", 64'(o_inst_ack), 64'd0);
    check("rst_ready_low", 64'(o_inst_ready), 64'd0);
    tick();
    i_rst = 0;
    settle();
    check("post_rst_ack", 64'(o_inst_ack), 64'd1);
    check("post_rst_count", 64'(o_count), 64'd0);
    check("post_rst_inst", 64'(o_inst), 64'd0);
    check("post_rst_pc", 64'(o_inst_pc), 64'd0);

    // Fill with decode stalled.
    for (int i = 0; i < 4; i++) begin
      i_inst_ready = 1; i_inst = fill_w[i]; i_inst_pc = AW'(4 * i);
      tick();
    end
    i_inst = 32'h1234; i_inst_pc = 12'h010;
    settle();
    check("full_count", 64'(o_count), 64'd4);
    check("full_ack", 64'(o_inst_ack), 64'd0);
    check("full_head", 64'(o_inst), 64'hF142);
    check("full_head_pc", 64'(o_inst_pc), 64'd0);
    tick();
    check("fifth_not_taken", 64'(o_count), 64'd4);
    i_inst_ready = 0;

    // Drain in order.
    i_inst_ack = 1;
    for (int i = 0; i < 4; i++) begin
      settle();
      check("drain_inst", 64'(o_inst), 64'(fill_w[i]));
      check("drain_pc", 64'(o_inst_pc), 64'(4 * i));
      tick();
    end
    settle();
    check("drained_count", 64'(o_count), 64'd0);
    check("drained_ready", 64'(o_inst_ready), 64'd0);

    // Streaming across pointer wrap.
    i_inst_ack = 0; i_inst_ready = 1; i_inst = 32'hA000; i_inst_pc = 12'h200;
    tick();
    i_inst_ack = 1;
    for (int k = 1; k <= 10; k++) begin
      i_inst = 32'hA000 + k; i_inst_pc = AW'(12'h200 + 4 * k);
      settle();
      check("stream_count", 64'(o_count), 64'd1);
      check("stream_inst", 64'(o_inst), 64'(32'hA000 + k - 1));
      tick();
    end
    i_inst_ready = 0;
    tick();
    check("stream_empty", 64'(o_count), 64'd0);

    // Flush with three entries queued.
    i_inst_ack = 0; i_inst_ready = 1;
    for (int i = 0; i < 3; i++) begin
      i_inst = 32'h9000 + 2 * i; i_inst_pc = AW'(12'h100 + 4 * i);
      tick();
    end
    i_flush = 1; i_inst = 32'h9008; i_inst_pc = 12'h10C;
    settle();
    check("flush_fwd", 64'(o_flush), 64'd1);
    check("flush_no_ack", 64'(o_inst_ack), 64'd0);
    check("flush_ready_low", 64'(o_inst_ready), 64'd0);
    tick();
    i_flush = 0; i_inst = 32'h900C; i_inst_pc = 12'h008;
    settle();
    check("flush_count0", 64'(o_count), 64'd0);
    tick();
    i_inst_ready = 0;
    settle();
    check("after_flush_head", 64'(o_inst), 64'h900C);
    check("after_flush_pc", 64'(o_inst_pc), 64'h008);
    check("after_flush_count", 64'(o_count), 64'd1);

    // Empty queue, decode acking while fetch presents a word.
    i_inst_ack = 1;
    tick();
    i_inst_ready = 1; i_inst = 32'hD142; i_inst_pc = 12'h020;
    settle();
`ifdef INST_QUEUE_BYPASS_EN
    check("byp_ready", 64'(o_inst_ready), 64'd1);
    check("byp_inst", 64'(o_inst), 64'hD142);
    tick();
    i_inst_ready = 0;
    settle();
    check("byp_count", 64'(o_count), 64'd0);
`else
    check("nobyp_ready", 64'(o_inst_ready), 64'd0);
    tick();
    i_inst_ready = 0;
    settle();
    check("nobyp_ready_next", 64'(o_inst_ready), 64'd1);
    check("nobyp_inst", 64'(o_inst), 64'hD142);
    tick();
`endif

    // Reset mid-stream clears queue and storage.
    i_inst_ack = 0; i_inst_ready = 1;
    for (int i = 0; i < 2; i++) begin
      i_inst = 32'h7700 + i; i_inst_pc = AW'(12'h300 + 4 * i);
      tick();
    end
    i_rst = 1; i_inst = 32'h7799;
    settle();
    check("midrst_no_ack", 64'(o_inst_ack), 64'd0);
    tick();
    i_rst = 0; i_inst_ready = 0;
    settle();
    check("midrst_count", 64'(o_count), 64'd0);
    check("midrst_inst", 64'(o_inst), 64'd0);
    tick();
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
